state_dump_unit: RTL and testbench
==================================

Name: state_dump_unit

Overview:
- Debug read-out engine for Simple_Single_CPU. On request it freezes the core, reads every register-file entry and then every data-memory word, and streams each as a tagged 32-bit record over a valid/ready interface.
- This puts the architectural-state readout (registers r0..r31, memory m0..m31) into RTL, so the result can be captured from silicon or FPGA without hierarchical probing.
- It sits beside the RF and DM as a second read port, with its hold output gating the PC and write enables.

Parameters:
- NUM_REGS, 32, number of register-file entries dumped (indices 0..NUM_REGS-1).
- NUM_WORDS, 32, number of data-memory words dumped (word indices 0..NUM_WORDS-1).
- DATA_W, 32, register/memory word width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  dump request; sampled only in IDLE
- busy_o  out  1  high from accepted start until done_o
- done_o  out  1  one-cycle pulse after the final record handshake
- halt_cpu_o  out  1  freeze CPU (PC hold, RF/DM write disable) while busy
- rf_addr_o  out  5  register-file read address
- rf_data_i  in  DATA_W  combinational RF read data
- dm_addr_o  out  32  data-memory byte address (word index * 4)
- dm_data_i  in  DATA_W  combinational DM read data
- out_valid_o  out  1  record valid
- out_ready_i  in  1  sink ready
- out_data_o  out  DATA_W  record payload
- out_tag_o  out  2  00 = register, 01 = memory, 10 = checksum (see option)
- out_idx_o  out  5  register number or memory word index

Behaviour:
- Reset (rst_i high at clock edge): state = IDLE.
  - All outputs 0: busy_o, done_o, halt_cpu_o, out_valid_o, out_data_o, out_tag_o, out_idx_o, rf_addr_o, dm_addr_o.
  - Index counter cleared.
  - Reset wins over every other input in the same cycle.
  - Reset mid-dump aborts the dump immediately; no done_o pulse.
- FSM states are IDLE, HALT, RD_REG, SEND_REG, RD_MEM, SEND_MEM, (CSUM), FIN.
- IDLE:
  - start_i = 1 moves to HALT and sets busy_o = 1 and halt_cpu_o = 1.
  - start_i is ignored in every other state; there is no queuing.
- HALT: one cycle, so any in-flight CPU write completes. Then go to RD_REG with idx = 0.
- RD_REG:
  - rf_addr_o = idx.
  - At the clock edge, out_data_o <= rf_data_i, out_tag_o <= 00, out_idx_o <= idx, out_valid_o <= 1.
  - Then go to SEND_REG.
- SEND_REG: hold out_data_o, out_tag_o and out_idx_o stable while out_valid_o && !out_ready_i. On handshake (valid && ready):
  - out_valid_o <= 0.
  - If idx == NUM_REGS-1: idx <= 0 and go to RD_MEM.
  - Otherwise: idx <= idx + 1 and go to RD_REG.
- RD_MEM / SEND_MEM: same as the register states, with these differences:
  - dm_addr_o = {idx, 2'b00}, zero-extended to 32 bits.
  - Tag is 01.
  - The last word goes to FIN (or to CSUM when the option is compiled in).
- FIN: one cycle with done_o = 1. busy_o and halt_cpu_o clear at the same edge. Return to IDLE.
- Throughput is one record per 2 cycles when out_ready_i is held high.
  - With start_i accepted at edge 0, record 0 is valid in cycle 3.
  - The last memory handshake occurs in cycle 129.
  - done_o is high in cycle 130.
- out_valid_o never drops without a handshake, except on reset.
- The out_ready_i value seen outside SEND states is ignored.
- Index counter width is 5 bits and never wraps within a region.
- halt_cpu_o stays high continuously from HALT through FIN.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - Keep a DATA_W accumulator that wraps mod 2^DATA_W.
  - Add each record's out_data_o on its handshake.
  - The accumulator is cleared when start_i is accepted.
  - After the last memory handshake, CSUM presents out_valid_o = 1, out_tag_o = 10, out_idx_o = 0, out_data_o = sum.
  - CSUM holds until handshake, then goes to FIN.
  - Timing with continuous ready: the checksum is valid in cycle 130 and done_o is high in cycle 131.
- Undefined: no accumulator logic, tag 10 is never emitted, and the SEND_MEM last word goes directly to FIN.

Decomposition:
- Shared package cpu_dbg_pkg holds:
  - FSM state enum.
  - Tag constants TAG_REG = 2'b00, TAG_MEM = 2'b01, TAG_CSUM = 2'b10.
  - Default NUM_REGS, NUM_WORDS and DATA_W.
- One natural sub-module: dump_out_reg, the valid/ready holding register for out_data_o, out_tag_o and out_idx_o (load / hold / clear).
- The FSM and index counter stay in state_dump_unit.

Test Plan:
- Preload r1=5, r29=128, m0=0x12345678, m31=0xFFFFFFFF; pulse start_i; hold out_ready_i=1.
  - Required: exactly 64 records in order (tags 00 idx 0..31, then 01 idx 0..31) with matching data.
  - Record 0 valid in cycle 3; done_o high only in cycle 130.
- Backpressure: drop out_ready_i for 5 cycles while register 7 is valid.
  - Required: out_data_o, out_tag_o and out_idx_o stay stable and out_valid_o stays 1.
  - No record is lost or duplicated.
- Pulse start_i again during record 10.
  - Required: ignored; only 64 records and a single done_o pulse.
- Assert rst_i while memory record 4 is valid.
  - Required: all outputs 0 next cycle, no done_o.
  - A subsequent start_i produces a full dump from register 0.
- Check halt_cpu_o over the whole dump.
  - Required: high from the cycle after start_i until the FIN cycle, low afterward.
  - CPU PC unchanged across the dump.
- DUMP_CHECKSUM_EN with r1=1, r2=2, m5=3, all else 0.
  - Required: the final record is tag 10 with data 6, followed by done_o.
  - Without the macro, no tag-10 record appears.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the Simple_Single_CPU debug state-dump path.
// Used by dump_out_reg and state_dump_unit.
package cpu_dbg_pkg;

  localparam int DEF_NUM_REGS  = 32;
  localparam int DEF_NUM_WORDS = 32;
  localparam int DEF_DATA_W    = 32;

  localparam int IDX_W = 5;
  localparam int TAG_W = 2;

  localparam logic [TAG_W-1:0] TAG_REG  = 2'b00;
  localparam logic [TAG_W-1:0] TAG_MEM  = 2'b01;
  localparam logic [TAG_W-1:0] TAG_CSUM = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_RD_REG,
    ST_SEND_REG,
    ST_RD_MEM,
    ST_SEND_MEM,
    ST_CSUM,
    ST_FIN
  } dump_state_e;

endpackage

// File: rtl/dump_out_reg.sv
// Valid/ready holding register for one dump record (payload, tag, index).
// A load takes priority over a clear so a new record can replace one being accepted.
module dump_out_reg
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [IDX_W-1:0]  idx_o
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      tag_o   <= '0;
      idx_o   <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
      tag_o   <= tag_i;
      idx_o   <= idx_i;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/state_dump_unit.sv
// Debug read-out engine: freezes the CPU, streams every RF entry then every DM word.
// Optional trailing checksum record when DUMP_CHECKSUM_EN is defined.
module state_dump_unit
  import cpu_dbg_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              halt_cpu_o,
  output logic [IDX_W-1:0]  rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [31:0]       dm_addr_o,
  input  logic [DATA_W-1:0] dm_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic [IDX_W-1:0]  out_idx_o
);

  localparam logic [IDX_W-1:0] LAST_REG  = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_WORDS - 1);

  dump_state_e       state;
  logic [IDX_W-1:0]  idx;
  logic              is_send;
  logic              handshake;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic [TAG_W-1:0]  load_tag;
  logic [IDX_W-1:0]  load_idx;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // The index register doubles as the read address for both storage ports.
  assign rf_addr_o = idx;
  assign dm_addr_o = {{(32 - IDX_W - 2){1'b0}}, idx, 2'b00};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    is_send   = 1'b0;
    load      = 1'b0;
    load_data = '0;
    load_tag  = TAG_REG;
    load_idx  = idx;
    case (state)
      ST_RD_REG: begin
        load      = 1'b1;
        load_data = rf_data_i;
        load_tag  = TAG_REG;
      end
      ST_RD_MEM: begin
        load      = 1'b1;
        load_data = dm_data_i;
        load_tag  = TAG_MEM;
      end
      ST_SEND_REG, ST_SEND_MEM: is_send = 1'b1;
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM:                  is_send = 1'b1;
`endif
      default: ;
    endcase
    handshake = is_send && out_valid_o && out_ready_i;
`ifdef DUMP_CHECKSUM_EN
    // The checksum record is loaded on the last memory handshake, so it must
    // already include the word being accepted at that edge.
    if (state == ST_SEND_MEM && handshake && idx == LAST_WORD) begin
      load      = 1'b1;
      load_data = csum + out_data_o;
      load_tag  = TAG_CSUM;
      load_idx  = '0;
    end
`endif
  end

  dump_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .clear_i (handshake),
    .data_i  (load_data),
    .tag_i   (load_tag),
    .idx_i   (load_idx),
    .valid_o (out_valid_o),
    .data_o  (out_data_o),
    .tag_o   (out_tag_o),
    .idx_o   (out_idx_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      idx        <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      halt_cpu_o <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state      <= ST_HALT;
            busy_o     <= 1'b1;
            halt_cpu_o <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        // One dead cycle lets any in-flight CPU write land before reading.
        ST_HALT: begin
          state <= ST_RD_REG;
          idx   <= '0;
        end
        ST_RD_REG: state <= ST_SEND_REG;
        ST_SEND_REG: begin
          if (handshake) begin
`ifdef DUMP_CHECKSUM_EN
            csum <= csum + out_data_o;
`endif
            if (idx == LAST_REG) begin
              idx   <= '0;
              state <= ST_RD_MEM;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_RD_REG;
            end
          end
        end
        ST_RD_MEM: state <= ST_SEND_MEM;
        ST_SEND_MEM: begin
          if (handshake) begin
`ifdef DUMP_CHECKSUM_EN
            csum <= csum + out_data_o;
`endif
            if (idx == LAST_WORD) begin
              idx <= '0;
`ifdef DUMP_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state  <= ST_FIN;
              done_o <= 1'b1;
`endif
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_RD_MEM;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (handshake) begin
            state  <= ST_FIN;
            done_o <= 1'b1;
          end
        end
`endif
        ST_FIN: begin
          state      <= ST_IDLE;
          busy_o     <= 1'b0;
          halt_cpu_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_state_dump_unit.sv
// Self-checking bench for state_dump_unit: table-driven dump runs with random
// backpressure against a record-list model, plus reset-abort and checksum sequences.
module tb_state_dump_unit;
  import cpu_dbg_pkg::*;

`ifdef DUMP_CHECKSUM_EN
  localparam int  DONE_CYC = 131;
  localparam bit  CSUM_ON  = 1'b1;
`else
  localparam int  DONE_CYC = 130;
  localparam bit  CSUM_ON  = 1'b0;
`endif
  localparam int MAX_CYC = 4000;

  typedef struct packed {
    logic [1:0]  tag;
    logic [4:0]  idx;
    logic [31:0] data;
  } rec_t;

  typedef struct {
    int ready_pct;
    bit stall7;
    bit restart10;
    int exp_first;
    int exp_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i, start_i, out_ready_i;
  logic        busy_o, done_o, halt_cpu_o, out_valid_o;
  logic [4:0]  rf_addr_o, out_idx_o;
  logic [31:0] dm_addr_o, rf_data_i, dm_data_i, out_data_o;
  logic [1:0]  out_tag_o;

  logic [31:0] rf [32];
  logic [31:0] dm [32];
  logic [31:0] pc;

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t got[$];
  rec_t exp_q[$];
  int   cyc, done_cnt, done_cyc, first_cyc, stab_err, halt_err, stall_left;
  int   pc0, pc_fin;
  bit   stall_pend, restarted;
  rec_t held;

  always #5 clk = ~clk;

  assign rf_data_i = rf[rf_addr_o];
  assign dm_data_i = dm[dm_addr_o[6:2]];

  // Toy CPU program counter: advances unless the dump unit freezes it.
  always @(posedge clk) begin
    if (rst_i) pc <= '0;
    else if (!halt_cpu_o) pc <= pc + 32'd4;
  end

  state_dump_unit dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .halt_cpu_o  (halt_cpu_o),
    .rf_addr_o   (rf_addr_o),
    .rf_data_i   (rf_data_i),
    .dm_addr_o   (dm_addr_o),
    .dm_data_i   (dm_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_tag_o   (out_tag_o),
    .out_idx_o   (out_idx_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every register in order, then every memory word, then the sum.
  task automatic build_expected();
    logic [31:0] sum;
    sum = '0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back('{tag: TAG_REG, idx: 5'(i), data: rf[i]});
      sum += rf[i];
    end
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back('{tag: TAG_MEM, idx: 5'(i), data: dm[i]});
      sum += dm[i];
    end
    if (CSUM_ON) exp_q.push_back('{tag: TAG_CSUM, idx: 5'd0, data: sum});
  endtask

  task automatic cycle_step(input vec_t v);
    logic rdy;
    rec_t cur;
    cur = '{tag: out_tag_o, idx: out_idx_o, data: out_data_o};
    rdy = ($urandom_range(0, 99) < v.ready_pct);
    if (stall_left > 0 && out_valid_o && out_tag_o == TAG_REG && out_idx_o == 5'd7) begin
      rdy = 1'b0;
      stall_left--;
    end
    start_i = 1'b0;
    if (v.restart10 && !restarted && out_valid_o && got.size() == 10) begin
      start_i   = 1'b1;
      restarted = 1'b1;
    end
    out_ready_i = rdy;
    if (stall_pend && (!out_valid_o || cur != held)) stab_err++;
    stall_pend = out_valid_o && !rdy;
    held       = cur;
    if (out_valid_o && first_cyc < 0) first_cyc = cyc;
    if (halt_cpu_o !== (done_cnt == 0) || busy_o !== (done_cnt == 0)) halt_err++;
    if (done_cnt > 0 && out_valid_o) halt_err++;
    if (out_valid_o && rdy) got.push_back(cur);
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      pc_fin   = pc;
    end
    tick();
    cyc++;
    start_i = 1'b0;
  endtask

  task automatic run_dump(input vec_t v, input string name);
    int mism;
    build_expected();
    got.delete();
    done_cnt = 0; done_cyc = -1; first_cyc = -1; stab_err = 0; halt_err = 0;
    stall_left = v.stall7 ? 5 : 0; stall_pend = 1'b0; restarted = 1'b0;
    start_i = 1'b1;
    tick();                      // start accepted at this edge (edge 0)
    start_i = 1'b0;
    cyc = 1;
    pc0 = pc;
    while (done_cnt == 0 && cyc < MAX_CYC) cycle_step(v);
    check({name, "_done_seen"}, done_cnt, 1);
    for (int i = 0; i < 8; i++) cycle_step(v);
    check({name, "_single_done"}, done_cnt, 1);
    check({name, "_rec_count"}, got.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] != exp_q[i]) mism++;
    check({name, "_rec_mismatch"}, mism, 0);
    check({name, "_stall_stable"}, stab_err, 0);
    check({name, "_halt_busy"}, halt_err, 0);
    check({name, "_pc_frozen"}, pc_fin, pc0);
    check({name, "_first_cyc"}, first_cyc, v.exp_first);
    if (v.exp_done >= 0) check({name, "_done_cyc"}, done_cyc, v.exp_done);
    out_ready_i = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom;
      dm[i] = $urandom;
    end
  endtask

  initial begin
    vec_t vecs[4];
    vec_t full;
    int   n, d, n_csum;

    vecs[0] = '{ready_pct: 100, stall7: 1'b0, restart10: 1'b0, exp_first: 3, exp_done: DONE_CYC};
    vecs[1] = '{ready_pct: 100, stall7: 1'b1, restart10: 1'b1, exp_first: 3, exp_done: DONE_CYC + 5};
    vecs[2] = '{ready_pct: 60,  stall7: 1'b0, restart10: 1'b1, exp_first: 3, exp_done: -1};
    vecs[3] = '{ready_pct: 30,  stall7: 1'b1, restart10: 1'b0, exp_first: 3, exp_done: -1};
    full    = vecs[0];

    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      dm[i] = '0;
    end

    // Reset with start held high: reset must win.
    rst_i = 1'b1; start_i = 1'b1; out_ready_i = 1'b1;
    tick();
    tick();
    check("rst_busy", busy_o, 0);
    check("rst_halt", halt_cpu_o, 0);
    check("rst_outputs", {done_o, out_valid_o, out_data_o, out_tag_o, out_idx_o, rf_addr_o, dm_addr_o}, '0);
    rst_i = 1'b0; start_i = 1'b0; out_ready_i = 1'b0;
    tick();

    for (int t = 0; t < 4; t++) begin
      load_random();
      if (t == 0) begin
        rf[1] = 32'd5; rf[29] = 32'd128; dm[0] = 32'h12345678; dm[31] = 32'hFFFFFFFF;
      end
      run_dump(vecs[t], $sformatf("vec%0d", t));
    end

    // Reset while memory record 4 is being offered aborts the dump.
    load_random();
    start_i = 1'b1; out_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (!(out_valid_o && out_tag_o == TAG_MEM && out_idx_o == 5'd4) && n < 300) begin
      tick();
      n++;
    end
    check("abort_reach_mem4", n < 300, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("abort_state", {busy_o, done_o, halt_cpu_o, out_valid_o}, '0);
    check("abort_payload", {out_data_o, out_tag_o, out_idx_o, rf_addr_o, dm_addr_o}, '0);
    d = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_o || busy_o) d++;
      tick();
    end
    check("abort_quiet", d, 0);
    out_ready_i = 1'b0;
    run_dump(full, "after_abort");

    // Checksum content: r1=1, r2=2, m5=3, everything else zero.
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      dm[i] = '0;
    end
    rf[1] = 32'd1; rf[2] = 32'd2; dm[5] = 32'd3;
    run_dump(full, "csum");
    n_csum = 0;
    foreach (got[i]) if (got[i].tag == TAG_CSUM) n_csum++;
    check("csum_tag_count", n_csum, CSUM_ON ? 1 : 0);
    if (got.size() > 0)
      check("csum_last_record", got[got.size()-1],
            CSUM_ON ? {TAG_CSUM, 5'd0, 32'd6} : {TAG_MEM, 5'd31, 32'd0});
    else
      check("csum_last_record", got.size(), 65);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
